// File: rtl/cic_interpolator_if.sv
// Sample stream bundle for the CIC interpolator: low-rate input handshake,
// high-rate output strobe and the output gain control.
interface cic_interpolator_if #(
  parameter int DATA_WIDTH = 12,
  parameter int GAIN_WIDTH = 2
);
  logic        [GAIN_WIDTH-1:0] gain;
  logic signed [DATA_WIDTH-1:0] data_in;
  logic                         data_in_valid;
  logic                         data_in_ready;
  logic signed [DATA_WIDTH-1:0] data_out;
  logic                         data_out_valid;

  modport master (
    output gain, data_in, data_in_valid,
    input  data_in_ready, data_out, data_out_valid
  );

  modport slave (
    input  gain, data_in, data_in_valid,
    output data_in_ready, data_out, data_out_valid
  );
endinterface

// File: rtl/cic_interpolator.sv
// N-stage CIC interpolator by R: comb chain at the input rate, zero stuffing,
// pipelined integrators at the clock rate, then gain shift and saturation.
module cic_interpolator #(
  parameter int DATA_WIDTH          = 12,
  parameter int INTERPOLATION_RATIO = 8,
  parameter int GAIN_WIDTH          = 2,
  parameter int N_STAGES            = 3,
  parameter int DDELAY              = 1
) (
  input  logic               clk,
  input  logic               arst_n,
  cic_interpolator_if.slave  bus
);
  localparam int R       = INTERPOLATION_RATIO;
  localparam int N       = N_STAGES;
  localparam int D       = DDELAY;
  localparam int RD_BITS = $clog2(R * D);
  localparam int W       = DATA_WIDTH + N * RD_BITS;
  localparam int PW      = $clog2(R);
  // Shift that normalises the DC gain (R*D)^N / R back to unity.
  localparam int SMAX    = N * RD_BITS - PW;

  localparam logic signed [W-1:0] SAT_HI = W'((2 ** (DATA_WIDTH - 1)) - 1);
  localparam logic signed [W-1:0] SAT_LO = ~SAT_HI;

  typedef enum logic {IDLE, RUN} state_t;

  state_t                          state, state_nxt;
  logic [PW-1:0]                   phase, phase_nxt;
  logic                            ready, ready_nxt;
  logic                            accept;

  logic [W-1:0]                    din_ext;
  logic [N-1:0][D-1:0][W-1:0]      comb_dly;
  logic [N-1:0][W-1:0]             stage_in;
  logic [W-1:0]                    comb_res;
  logic [W-1:0]                    comb_out;
  logic [W-1:0]                    acc;

  logic [N-1:0][W-1:0]             integ;

  int                              shamt;
  logic signed [W-1:0]             scaled;
  logic [DATA_WIDTH-1:0]           sat_val;
  logic [DATA_WIDTH-1:0]           out_data;
  logic                            out_vld;

  assign accept  = bus.data_in_valid & ready;
  assign din_ext = {{(W - DATA_WIDTH){bus.data_in[DATA_WIDTH-1]}}, bus.data_in};

  assign bus.data_in_ready  = ready;
  assign bus.data_out       = out_data;
  assign bus.data_out_valid = out_vld;

  // Next state, phase and ready: a new sample is admitted only in IDLE or in
  // the last phase of a burst, which gives one accept per R cycles.
  always_comb begin
    state_nxt = state;
    phase_nxt = phase;
    case (state)
      IDLE: begin
        if (accept) begin
          state_nxt = RUN;
          phase_nxt = '0;
        end
      end
      RUN: begin
        if (phase == PW'(R - 1)) begin
          if (accept) phase_nxt = '0;
          else        state_nxt = IDLE;
        end else begin
          phase_nxt = phase + 1'b1;
        end
      end
      default: state_nxt = IDLE;
    endcase
    ready_nxt = (state_nxt == IDLE) || (phase_nxt == PW'(R - 1));
  end

  // Control state registers.
  always_ff @(posedge clk or negedge arst_n) begin
    if (!arst_n) begin
      state <= IDLE;
      phase <= '0;
      ready <= 1'b0;
    end else begin
      state <= state_nxt;
      phase <= phase_nxt;
      ready <= ready_nxt;
    end
  end

  // Comb chain: each stage subtracts its input from D accepts ago.
  always_comb begin
    stage_in = '0;
    acc      = din_ext;
    for (int i = 0; i < N; i++) begin
      stage_in[i] = acc;
      acc         = acc - comb_dly[i][D-1];
    end
    comb_res = acc;
  end

  // Comb delay lines and comb result advance only on accepted samples.
  always_ff @(posedge clk or negedge arst_n) begin
    if (!arst_n) begin
      comb_dly <= '0;
      comb_out <= '0;
    end else if (accept) begin
      for (int i = 0; i < N; i++) begin
        comb_dly[i][0] <= stage_in[i];
        for (int k = 1; k < D; k++) comb_dly[i][k] <= comb_dly[i][k-1];
      end
      comb_out <= comb_res;
    end
  end

  // Integrators run once per RUN cycle; the first sees the comb result only
  // at phase 0 (zero stuffing), later stages add the previous stage's register.
  always_ff @(posedge clk or negedge arst_n) begin
    if (!arst_n) begin
      integ <= '0;
    end else if (state == RUN) begin
      integ[0] <= integ[0] + ((phase == '0) ? comb_out : '0);
      for (int i = 1; i < N; i++) integ[i] <= integ[i] + integ[i-1];
    end
  end

  // Gain-adjusted arithmetic shift followed by saturation to the sample range.
  always_comb begin
    shamt  = (SMAX > int'(bus.gain)) ? SMAX - int'(bus.gain) : 0;
    scaled = $signed(integ[N-1]) >>> shamt;
    if (scaled > SAT_HI)      sat_val = SAT_HI[DATA_WIDTH-1:0];
    else if (scaled < SAT_LO) sat_val = SAT_LO[DATA_WIDTH-1:0];
    else                      sat_val = scaled[DATA_WIDTH-1:0];
  end

  // Output register: one strobe per RUN cycle, data held otherwise.
  always_ff @(posedge clk or negedge arst_n) begin
    if (!arst_n) begin
      out_vld  <= 1'b0;
      out_data <= '0;
    end else begin
      out_vld <= (state == RUN);
      if (state == RUN) out_data <= sat_val;
    end
  end
endmodule

// File: tb/tb_cic_interpolator.sv
// Directed bench for cic_interpolator (R=8, N=3, D=1): table of constant-input
// vectors with settled outputs, plus reset, single-sample and mid-burst reset
// sequences.
module tb_cic_interpolator;
  localparam int DW = 12;
  localparam int GW = 2;

  logic clk    = 1'b0;
  logic arst_n = 1'b0;

  cic_interpolator_if #(.DATA_WIDTH(DW), .GAIN_WIDTH(GW)) bus ();

  cic_interpolator #(
    .DATA_WIDTH(DW), .INTERPOLATION_RATIO(8), .GAIN_WIDTH(GW),
    .N_STAGES(3), .DDELAY(1)
  ) dut (
    .clk(clk), .arst_n(arst_n), .bus(bus)
  );

  always #5 clk = ~clk;

  int checks = 0;
  int errors = 0;

  typedef struct {
    int din;
    int gain;
    int exp;
  } vec_t;

  vec_t vecs [10];

  task automatic chk(input string name, input int act, input int exp);
    checks++;
    if (act != exp) begin
      errors++;
      $display("FAIL %s: got %0d expected %0d", name, act, exp);
    end
  endtask

  task automatic do_reset();
    bus.data_in_valid = 1'b0;
    bus.data_in       = '0;
    @(negedge clk);
    arst_n = 1'b0;
    @(negedge clk);
    @(negedge clk);
    arst_n = 1'b1;
  endtask

  // Drive a constant input with valid held high for 100 cycles and check the
  // settled output, steady-state cadence and that no output leaves [0, exp].
  task automatic run_vec(input int din, input int gain, input int exp, input string tag);
    int lo, hi, bad, rdy, vld, v;
    lo = (exp < 0) ? exp : 0;
    hi = (exp > 0) ? exp : 0;
    bad = 0; rdy = 0; vld = 0;
    bus.gain          = GW'(gain);
    bus.data_in       = DW'(din);
    bus.data_in_valid = 1'b1;
    for (int c = 0; c < 100; c++) begin
      @(posedge clk); #1;
      v = bus.data_out;
      if (bus.data_out_valid && (v < lo || v > hi)) bad++;
      if (c >= 36) begin
        rdy += int'(bus.data_in_ready);
        vld += int'(bus.data_out_valid);
      end
    end
    v = bus.data_out;
    chk({tag, " settle"}, v, exp);
    chk({tag, " ready_count"}, rdy, 8);
    chk({tag, " valid_count"}, vld, 64);
    chk({tag, " out_of_range"}, bad, 0);
    bus.data_in_valid = 1'b0;
  endtask

  // Wait (bounded) until ready is seen high after an edge.
  task automatic wait_ready(input string tag, output bit found);
    found = 1'b0;
    for (int c = 0; c < 20 && !found; c++) begin
      @(posedge clk); #1;
      if (bus.data_in_ready) found = 1'b1;
    end
    if (!found) chk({tag, " ready_timeout"}, 0, 1);
  endtask

  initial begin
    int v, cnt, nz;
    bit found;

    vecs[0] = '{din:  100,  gain: 0, exp:  100};
    vecs[1] = '{din:  100,  gain: 3, exp:  800};
    vecs[2] = '{din:  100,  gain: 1, exp:  200};
    vecs[3] = '{din:  100,  gain: 2, exp:  400};
    vecs[4] = '{din:  2047, gain: 3, exp:  2047};
    vecs[5] = '{din: -2048, gain: 3, exp: -2048};
    vecs[6] = '{din: -300,  gain: 0, exp: -300};
    vecs[7] = '{din: -300,  gain: 2, exp: -1200};
    vecs[8] = '{din:  2047, gain: 0, exp:  2047};
    vecs[9] = '{din:  0,    gain: 1, exp:  0};

    bus.gain          = '0;
    bus.data_in       = '0;
    bus.data_in_valid = 1'b0;

    // Reset state and first edge after release.
    #2;
    chk("rst ready", int'(bus.data_in_ready), 0);
    chk("rst valid", int'(bus.data_out_valid), 0);
    v = bus.data_out;
    chk("rst data_out", v, 0);
    @(negedge clk);
    arst_n = 1'b1;
    #1;
    chk("release ready before edge", int'(bus.data_in_ready), 0);
    @(posedge clk); #1;
    chk("release ready after edge", int'(bus.data_in_ready), 1);
    cnt = 0; nz = 0;
    for (int c = 0; c < 10; c++) begin
      @(posedge clk); #1;
      cnt += int'(bus.data_out_valid);
      if (bus.data_out != 0) nz++;
    end
    chk("idle valid pulses", cnt, 0);
    chk("idle data_out nonzero", nz, 0);

    // Table of constant-input vectors, each from a fresh reset.
    for (int i = 0; i < 10; i++) begin
      do_reset();
      run_vec(vecs[i].din, vecs[i].gain, vecs[i].exp, $sformatf("vec%0d", i));
    end

    // Single sample: exactly R output strobes, back to IDLE, then decay.
    do_reset();
    bus.gain          = '0;
    bus.data_in       = DW'(1000);
    bus.data_in_valid = 1'b1;
    wait_ready("single", found);
    @(posedge clk); #1;
    bus.data_in_valid = 1'b0;
    bus.data_in       = '0;
    cnt = 0;
    for (int c = 0; c < 30; c++) begin
      cnt += int'(bus.data_out_valid);
      @(posedge clk); #1;
    end
    chk("single valid pulses", cnt, 8);
    chk("single ready idle", int'(bus.data_in_ready), 1);
    bus.data_in_valid = 1'b1;
    cnt = 0; nz = 0;
    for (int c = 0; c < 60; c++) begin
      @(posedge clk); #1;
      if (bus.data_out_valid) begin
        cnt++;
        if (cnt >= 29 && bus.data_out != 0) nz++;
      end
    end
    chk("decay nonzero after 29", nz, 0);
    chk("decay output count", cnt, 59);
    bus.data_in_valid = 1'b0;

    // Reset asserted at phase 4 of a running burst.
    do_reset();
    bus.gain          = '0;
    bus.data_in       = DW'(100);
    bus.data_in_valid = 1'b1;
    repeat (40) @(posedge clk);
    #1;
    wait_ready("midrst", found);
    @(posedge clk);
    repeat (4) @(posedge clk);
    #1;
    chk("midrst valid before", int'(bus.data_out_valid), 1);
    #2;
    arst_n = 1'b0;
    bus.data_in_valid = 1'b0;
    #1;
    v = bus.data_out;
    chk("midrst data_out", v, 0);
    chk("midrst valid", int'(bus.data_out_valid), 0);
    chk("midrst ready", int'(bus.data_in_ready), 0);
    @(negedge clk);
    @(negedge clk);
    arst_n = 1'b1;
    cnt = 0;
    for (int c = 0; c < 12; c++) begin
      @(posedge clk); #1;
      cnt += int'(bus.data_out_valid);
    end
    chk("midrst no pulses", cnt, 0);
    chk("midrst idle ready", int'(bus.data_in_ready), 1);
    run_vec(100, 0, 100, "restart");

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule
